// File: rtl/sdr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdr_req_arbiter
// Function : Round-robin merge of N ROM fetch clients onto one SDRAM ROM
//            manager port, one request outstanding, responses routed back.
// Revision : 1.0 - initial release
// ============================================================================
module sdr_req_arbiter #(
    parameter int N  = 4,
    parameter int AW = 25,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    cli_req,
    input  logic [N*AW-1:0] cli_addr,
    output logic [DW-1:0]   cli_data,
    output logic [N-1:0]    cli_rdy,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_req,
    input  logic [DW-1:0]   rom_data,
    input  logic            rom_rdy
);

    localparam int             c_lw       = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_lw-1:0] c_last_rst = c_lw'(N - 1);
    localparam logic [N-1:0]   c_one      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_req_d;
    logic [N-1:0]    r_pend;
    logic [AW-1:0]   r_padr [N];
    logic [c_lw-1:0] r_gnt;
    logic [c_lw-1:0] r_last;

    logic [N-1:0]    w_edge;
    logic [N-1:0]    w_done;
    logic            w_found;
    logic [c_lw-1:0] w_win;
    logic [c_lw:0]   w_idx;

    assign w_edge = cli_req & ~r_req_d;

    always_comb begin
        w_done = '0;
        if (r_state == S_WAIT && rom_rdy) begin
            w_done = c_one << r_gnt;
        end
    end

    // Scan last+1, last+2, ... wrapping modulo N; the first pending client wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = {1'b0, r_last} + (c_lw+1)'(k);
            if (w_idx >= (c_lw+1)'(N)) begin
                w_idx = w_idx - (c_lw+1)'(N);
            end
            if (!w_found && r_pend[w_idx[c_lw-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_lw-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_req_d  <= '0;
            r_pend   <= '0;
            r_gnt    <= '0;
            r_last   <= c_last_rst;
            cli_data <= '0;
            cli_rdy  <= '0;
            rom_addr <= '0;
            rom_req  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_padr[i] <= '0;
            end
        end else begin
            r_req_d <= cli_req;
            rom_req <= 1'b0;
            cli_rdy <= '0;

            // A fresh edge landing on its own completion re-arms the client.
            for (int i = 0; i < N; i++) begin
                if (w_edge[i] && (!r_pend[i] || w_done[i])) begin
                    r_pend[i] <= 1'b1;
                    r_padr[i] <= cli_addr[i*AW +: AW];
                end else if (w_done[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_win;
                        r_last   <= w_win;
                        rom_addr <= r_padr[w_win];
                        rom_req  <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rom_rdy) begin
                        cli_data <= rom_data;
                        cli_rdy  <= w_done;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
